// File: rtl/rx_frame_ctrl_pkg.sv
// Shared definitions for the UART RX frame sequencer and the blocks that
// decode its one-hot frame state.
package rx_frame_ctrl_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } frame_state_e;

  localparam logic [3:0] LAST_DATA_BIT = 4'd7;

  function automatic logic is_falling_edge(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Serial input plus frame-state/strobe bundle between the RX sequencer and
// the shift register / byte analyser.
interface rx_frame_ctrl_if;
  import rx_frame_ctrl_pkg::*;

  logic               rx_i;
  logic               p_ParityEnable_i;
  logic [STATE_W-1:0] State_o;
  logic [3:0]         BitCounter_o;
  logic               Bit_Synch_o;
  logic               p_Bit_o;
  logic               p_ByteDone_o;
  logic               p_FrameError_o;
  logic               p_Busy_o;

  modport master (
    output rx_i, p_ParityEnable_i,
    input  State_o, BitCounter_o, Bit_Synch_o, p_Bit_o,
           p_ByteDone_o, p_FrameError_o, p_Busy_o
  );

  modport slave (
    input  rx_i, p_ParityEnable_i,
    output State_o, BitCounter_o, Bit_Synch_o, p_Bit_o,
           p_ByteDone_o, p_FrameError_o, p_Busy_o
  );

endinterface

// File: rtl/rx_baud_counter.sv
// Bit-period timer: counts clock cycles within a serial bit and flags the
// half-bit and full-bit terminal counts.
module rx_baud_counter #(
  parameter int CLK_PER_BIT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic half_tc,
  output logic full_tc
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter with clear taking priority over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign half_tc = (cnt_r == HALF_LAST);
  assign full_tc = (cnt_r == FULL_LAST);

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART RX frame sequencer: start-bit detection, bit timing, one-hot frame
// state, bit counter and sample/frame strobes for downstream RX blocks.
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            rst,
  rx_frame_ctrl_if.slave bus
);

  frame_state_e state_r, state_nxt_s;
  logic         rx_prev_r, rx_prev_nxt_s;
  logic         par_en_r, par_en_nxt_s;
  logic [3:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic         sync_r, sync_nxt_s;
  logic         bit_r, bit_nxt_s;
  logic         done_r, done_nxt_s;
  logic         ferr_r, ferr_nxt_s;
  logic         busy_r, busy_nxt_s;
  logic         baud_clr_s, baud_en_s, half_tc_s, full_tc_s;

  rx_baud_counter #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (baud_clr_s),
    .en      (baud_en_s),
    .half_tc (half_tc_s),
    .full_tc (full_tc_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nxt_s   = state_r;
    rx_prev_nxt_s = bus.rx_i;
    par_en_nxt_s  = par_en_r;
    bit_cnt_nxt_s = bit_cnt_r;
    sync_nxt_s    = 1'b0;
    bit_nxt_s     = bit_r;
    done_nxt_s    = 1'b0;
    ferr_nxt_s    = 1'b0;
    baud_clr_s    = 1'b0;
    baud_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_clr_s = 1'b1;
        if (is_falling_edge(rx_prev_r, bus.rx_i)) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (half_tc_s) begin
          baud_clr_s = 1'b1;
          if (!bus.rx_i) begin
            state_nxt_s   = ST_DATA;
            bit_cnt_nxt_s = 4'd0;
            par_en_nxt_s  = bus.p_ParityEnable_i;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          baud_en_s = 1'b1;
        end
      end
      ST_DATA: begin
        if (full_tc_s) begin
          baud_clr_s    = 1'b1;
          sync_nxt_s    = 1'b1;
          bit_nxt_s     = bus.rx_i;
          bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r == LAST_DATA_BIT) begin
            state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          baud_en_s = 1'b1;
        end
      end
      ST_PARITY: begin
        if (full_tc_s) begin
          baud_clr_s  = 1'b1;
          sync_nxt_s  = 1'b1;
          bit_nxt_s   = bus.rx_i;
          state_nxt_s = ST_STOP;
        end else begin
          baud_en_s = 1'b1;
        end
      end
      ST_STOP: begin
        if (full_tc_s) begin
          baud_clr_s  = 1'b1;
          state_nxt_s = ST_IDLE;
          if (bus.rx_i) begin
            done_nxt_s = 1'b1;
          end else begin
            // A low stop bit must see the line return high before re-arming
            ferr_nxt_s    = 1'b1;
            rx_prev_nxt_s = 1'b0;
          end
        end else begin
          baud_en_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        baud_clr_s  = 1'b1;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rx_prev_r <= 1'b1;
      par_en_r  <= 1'b0;
      bit_cnt_r <= 4'd0;
      sync_r    <= 1'b0;
      bit_r     <= 1'b0;
      done_r    <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rx_prev_r <= rx_prev_nxt_s;
      par_en_r  <= par_en_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      sync_r    <= sync_nxt_s;
      bit_r     <= bit_nxt_s;
      done_r    <= done_nxt_s;
      ferr_r    <= ferr_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign bus.State_o        = state_r;
  assign bus.BitCounter_o   = bit_cnt_r;
  assign bus.Bit_Synch_o    = sync_r;
  assign bus.p_Bit_o        = bit_r;
  assign bus.p_ByteDone_o   = done_r;
  assign bus.p_FrameError_o = ferr_r;
  assign bus.p_Busy_o       = busy_r;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed frame table with fixed timing offsets,
// then random frames checked cycle by cycle against a timing-formula model.
module tb_rx_frame_ctrl;
  import rx_frame_ctrl_pkg::*;

  localparam int N    = 16;
  localparam int MAXC = 20000;
  localparam int NV   = 9;

  logic clk = 1'b0;
  logic rst;

  rx_frame_ctrl_if bus();

  rx_frame_ctrl #(.CLK_PER_BIT(N), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected per-cycle waveform, built from frame timing formulas
  logic       rst_w  [MAXC];
  logic       rx_w   [MAXC];
  logic       pe_w   [MAXC];
  logic [4:0] st_w   [MAXC];
  logic       sync_w [MAXC];
  logic       bit_w  [MAXC];
  logic [3:0] bc_w   [MAXC];
  logic       done_w [MAXC];
  logic       ferr_w [MAXC];
  // Observed outputs, for the table offset checks
  logic [4:0] obs_st   [MAXC];
  logic       obs_sync [MAXC];
  logic       obs_done [MAXC];
  logic       obs_ferr [MAXC];

  int wp = 0;
  int rp = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] m_bc = 4'd0;
  logic       m_bit = 1'b0;
  logic       done_pend = 1'b0;
  logic       ferr_pend = 1'b0;

  typedef struct {
    int         kind;     // 0 frame, 1 glitch
    logic [7:0] d;
    logic       pe;
    logic       pbit;
    logic       stopv;
    int         hold;     // frame: low cycles after bad stop; glitch: low length
    int         gap;
    int         pe_after;
    int         abort;
    int         x_sync;
    int         x_done;
    int         x_ferr;
    int         x_idle;
  } vec_t;

  vec_t tbl [NV];
  int   vec_e [NV];

  function automatic logic rnd_bit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic rx, input logic pe, input logic [4:0] st, input logic sy);
    if (wp >= MAXC) begin
      $display("FAIL waveform_buffer at cycle %0d: got overflow, expected < %0d", wp, MAXC);
      $fatal(1);
    end
    rst_w[wp]  = r;
    rx_w[wp]   = rx;
    pe_w[wp]   = pe;
    st_w[wp]   = st;
    sync_w[wp] = sy;
    bc_w[wp]   = m_bc;
    bit_w[wp]  = m_bit;
    done_w[wp] = done_pend;
    ferr_w[wp] = ferr_pend;
    done_pend  = 1'b0;
    ferr_pend  = 1'b0;
    wp++;
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, rnd_bit(), ST_IDLE, 1'b0);
  endtask

  // One frame: edge at i=0, bit k sampled at N/2+(k+1)N, stop sample at last
  task automatic gen_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic stopv,
                           input int hold, input int gap, input int pe_after, input int abort);
    logic [10:0] bits;
    logic [4:0]  st;
    logic        sy, pev;
    int          nb, last, k;
    nb = pe ? 9 : 8;
    bits = 11'd0;
    for (int j = 0; j < 8; j++) bits[j+1] = d[j];
    if (pe) bits[9] = pbit;
    bits[nb+1] = stopv;
    last = N/2 + (nb + 1) * N;
    for (int i = 0; i <= last; i++) begin
      if (i <= N/2) pev = pe;
      else if (pe_after < 0) pev = rnd_bit();
      else pev = (pe_after != 0);
      if (i == 0) st = ST_IDLE;
      else if (i <= N/2) st = ST_START;
      else if (i <= N/2 + 8*N) st = ST_DATA;
      else if (pe && i <= N/2 + 9*N) st = ST_PARITY;
      else st = ST_STOP;
      if (i == N/2 + 1) m_bc = 4'd0;
      sy = 1'b0;
      if (i > N/2 + 1 && ((i - N/2 - 1) % N) == 0) begin
        k     = (i - N/2 - 1) / N - 1;
        sy    = 1'b1;
        m_bit = bits[k+1];
        m_bc  = (k + 1 > 8) ? 4'd8 : 4'(k + 1);
      end
      if (i == abort) begin
        push(1'b1, bits[i/N], pev, st, sy);
        m_bc  = 4'd0;
        m_bit = 1'b0;
        gen_idle(gap < 1 ? 1 : gap);
        return;
      end
      push(1'b0, bits[i/N], pev, st, sy);
    end
    if (stopv) begin
      done_pend = 1'b1;
      gen_idle(gap);
    end else begin
      ferr_pend = 1'b1;
      for (int i = 0; i < hold; i++) push(1'b0, 1'b0, rnd_bit(), ST_IDLE, 1'b0);
      gen_idle(gap < 1 ? 1 : gap);
    end
  endtask

  // False start: low for len cycles (len <= N/2), back to IDLE after the check
  task automatic gen_glitch(input int len, input int after);
    logic [4:0] st;
    for (int i = 0; i <= N/2 + after; i++) begin
      if (i == 0) st = ST_IDLE;
      else if (i <= N/2) st = ST_START;
      else st = ST_IDLE;
      push(1'b0, (i < len) ? 1'b0 : 1'b1, rnd_bit(), st, 1'b0);
    end
  endtask

  task automatic run_to_wp();
    for (int c = rp; c < wp; c++) begin
      rst = rst_w[c];
      bus.rx_i = rx_w[c];
      bus.p_ParityEnable_i = pe_w[c];
      obs_st[c]   = bus.State_o;
      obs_sync[c] = bus.Bit_Synch_o;
      obs_done[c] = bus.p_ByteDone_o;
      obs_ferr[c] = bus.p_FrameError_o;
      chk("state", c, 32'(bus.State_o), 32'(st_w[c]));
      chk("busy", c, 32'(bus.p_Busy_o), 32'(st_w[c] != ST_IDLE));
      chk("bit_synch", c, 32'(bus.Bit_Synch_o), 32'(sync_w[c]));
      chk("bit_counter", c, 32'(bus.BitCounter_o), 32'(bc_w[c]));
      chk("p_bit", c, 32'(bus.p_Bit_o), 32'(bit_w[c]));
      chk("byte_done", c, 32'(bus.p_ByteDone_o), 32'(done_w[c]));
      chk("frame_error", c, 32'(bus.p_FrameError_o), 32'(ferr_w[c]));
      @(posedge clk);
      #1;
    end
    rp = wp;
  endtask

  initial begin
    int lo, hi, ns, od, of, oi, r;

    tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, 0,  5, 0, -1, 8, 153, -1, 153};
    tbl[1] = '{0, 8'h3C, 1'b1, 1'b0, 1'b1, 0,  5, 1, -1, 9, 169, -1, 169};
    tbl[2] = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 4,  3, 0, -1, 0, -1,  -1, 9};
    tbl[3] = '{0, 8'h5A, 1'b0, 1'b0, 1'b0, 50, 4, 0, -1, 8, -1,  153, 153};
    tbl[4] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 0, 10, 0, 70, 3, -1,  -1, 71};
    tbl[5] = '{0, 8'h81, 1'b0, 1'b0, 1'b1, 0,  0, 0, -1, 8, 153, -1, 153};
    tbl[6] = '{0, 8'h96, 1'b1, 1'b1, 1'b1, 0,  3, 0, -1, 9, 169, -1, 169};
    tbl[7] = '{0, 8'h42, 1'b0, 1'b0, 1'b1, 0,  3, 1, -1, 8, 153, -1, 153};
    tbl[8] = '{0, 8'h00, 1'b1, 1'b1, 1'b0, 0,  1, 0, -1, 9, -1,  169, 169};

    rst = 1'b1;
    bus.rx_i = 1'b1;
    bus.p_ParityEnable_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", -1, 32'(bus.State_o), 32'(ST_IDLE));
    chk("reset_bit_counter", -1, 32'(bus.BitCounter_o), 32'd0);
    chk("reset_bit_synch", -1, 32'(bus.Bit_Synch_o), 32'd0);
    chk("reset_p_bit", -1, 32'(bus.p_Bit_o), 32'd0);
    chk("reset_byte_done", -1, 32'(bus.p_ByteDone_o), 32'd0);
    chk("reset_frame_error", -1, 32'(bus.p_FrameError_o), 32'd0);
    chk("reset_busy", -1, 32'(bus.p_Busy_o), 32'd0);

    gen_idle(3);
    for (int v = 0; v < NV; v++) begin
      vec_e[v] = wp;
      if (tbl[v].kind == 1) gen_glitch(tbl[v].hold, tbl[v].gap);
      else gen_frame(tbl[v].d, tbl[v].pe, tbl[v].pbit, tbl[v].stopv, tbl[v].hold,
                     tbl[v].gap, tbl[v].pe_after, tbl[v].abort);
    end
    gen_idle(4);
    run_to_wp();

    for (int v = 0; v < NV; v++) begin
      lo = vec_e[v] + 1;
      hi = (v + 1 < NV) ? vec_e[v+1] : wp - 1;
      ns = 0; od = -1; of = -1; oi = -1;
      for (int c = lo; c <= hi; c++) begin
        if (obs_sync[c]) ns++;
        if (obs_done[c] && od < 0) od = c - vec_e[v];
        if (obs_ferr[c] && of < 0) of = c - vec_e[v];
        if (obs_st[c] == ST_IDLE && oi < 0) oi = c - vec_e[v];
      end
      chk($sformatf("tbl%0d_sync_count", v), vec_e[v], 32'(ns), 32'(tbl[v].x_sync));
      chk($sformatf("tbl%0d_done_offset", v), vec_e[v], 32'(od), 32'(tbl[v].x_done));
      chk($sformatf("tbl%0d_ferr_offset", v), vec_e[v], 32'(of), 32'(tbl[v].x_ferr));
      chk($sformatf("tbl%0d_idle_offset", v), vec_e[v], 32'(oi), 32'(tbl[v].x_idle));
    end

    for (int it = 0; it < 45; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        gen_glitch(int'($urandom_range(1, N/2)), int'($urandom_range(0, 3)));
      end else if (r == 2) begin
        gen_frame(8'($urandom), rnd_bit(), rnd_bit(), 1'b1, 0,
                  int'($urandom_range(1, 4)), -1, int'($urandom_range(1, 150)));
      end else begin
        gen_frame(8'($urandom), rnd_bit(), rnd_bit(), ($urandom_range(0, 4) != 0),
                  int'($urandom_range(0, 50)), int'($urandom_range(0, 4)), -1, -1);
      end
    end
    gen_idle(4);
    run_to_wp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
